// File: rtl/ovi_issue_tracker_if.sv
// Core/OVI signal bundle for the issue tracker. The tracker connects through
// the master modport and the core/VPU side through the slave modport.
interface ovi_issue_tracker_if #(
  parameter int SBID_W = 5
);
  logic              CORE_ISSUE_VALID;
  logic [31:0]       CORE_ISSUE_INSTR;
  logic [2:0]        CORE_ISSUE_SEW;
  logic [14:0]       CORE_ISSUE_VL;
  logic              CORE_FENCE;
  logic              CORE_HALT;
  logic              CORE_COMPLETED_VALID;
  logic [63:0]       CORE_COMPLETED_DATA;
  logic [SBID_W-1:0] CORE_COMPLETED_SBID;

  logic              VPU_ISSUE_VALID;
  logic [31:0]       VPU_ISSUE_INSTR;
  logic [SBID_W-1:0] VPU_ISSUE_SBID;
  logic [2:0]        VPU_ISSUE_VSEW;
  logic [14:0]       VPU_ISSUE_VL;
  logic [13:0]       VPU_ISSUE_VSTART;
  logic [1:0]        VPU_ISSUE_VXRM;
  logic [2:0]        VPU_ISSUE_FRM;
  logic [2:0]        VPU_ISSUE_VLMUL;
  logic              VPU_ISSUE_VILL;
  logic [63:0]       VPU_ISSUE_SCALAR_OPND;
  logic              VPU_ISSUE_CREDIT;

  logic              VPU_DISPATCH_NEXT_SENIOR;
  logic              VPU_DISPATCH_KILL;
  logic [SBID_W-1:0] VPU_DISPATCH_SBID;

  logic              VPU_COMPLETED_VALID;
  logic [SBID_W-1:0] VPU_COMPLETED_SBID;
  logic [63:0]       VPU_COMPLETED_DEST;

  modport master (
    input  CORE_ISSUE_VALID, CORE_ISSUE_INSTR, CORE_ISSUE_SEW, CORE_ISSUE_VL, CORE_FENCE,
    output CORE_HALT, CORE_COMPLETED_VALID, CORE_COMPLETED_DATA, CORE_COMPLETED_SBID,
    output VPU_ISSUE_VALID, VPU_ISSUE_INSTR, VPU_ISSUE_SBID, VPU_ISSUE_VSEW, VPU_ISSUE_VL,
    output VPU_ISSUE_VSTART, VPU_ISSUE_VXRM, VPU_ISSUE_FRM, VPU_ISSUE_VLMUL, VPU_ISSUE_VILL,
    output VPU_ISSUE_SCALAR_OPND,
    input  VPU_ISSUE_CREDIT,
    output VPU_DISPATCH_NEXT_SENIOR, VPU_DISPATCH_KILL, VPU_DISPATCH_SBID,
    input  VPU_COMPLETED_VALID, VPU_COMPLETED_SBID, VPU_COMPLETED_DEST
  );

  modport slave (
    output CORE_ISSUE_VALID, CORE_ISSUE_INSTR, CORE_ISSUE_SEW, CORE_ISSUE_VL, CORE_FENCE,
    input  CORE_HALT, CORE_COMPLETED_VALID, CORE_COMPLETED_DATA, CORE_COMPLETED_SBID,
    input  VPU_ISSUE_VALID, VPU_ISSUE_INSTR, VPU_ISSUE_SBID, VPU_ISSUE_VSEW, VPU_ISSUE_VL,
    input  VPU_ISSUE_VSTART, VPU_ISSUE_VXRM, VPU_ISSUE_FRM, VPU_ISSUE_VLMUL, VPU_ISSUE_VILL,
    input  VPU_ISSUE_SCALAR_OPND,
    output VPU_ISSUE_CREDIT,
    input  VPU_DISPATCH_NEXT_SENIOR, VPU_DISPATCH_KILL, VPU_DISPATCH_SBID,
    output VPU_COMPLETED_VALID, VPU_COMPLETED_SBID, VPU_COMPLETED_DEST
  );
endinterface

// File: rtl/ovi_issue_tracker.sv
// OVI issue tracker: credit counting, sb_id scoreboard, registered dispatch
// and completion forwarding between a scalar core and a vector unit.
module ovi_issue_tracker #(
  parameter int MAX_CREDITS     = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int SBID_W          = 5,
  localparam int CW = $clog2(MAX_CREDITS + 1),
  localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                   CLK,
  input  logic                   RST,
  ovi_issue_tracker_if.master    bus,
  output logic [OW-1:0]          OUTSTANDING,
  output logic                   ERR
);

  logic [CW-1:0]              credits_q, credits_d;
  logic [MAX_OUTSTANDING-1:0] alloc_q, alloc_d;
  logic [OW-1:0]              outstanding_q, outstanding_d;
  logic                       err_q, err_d;
  logic                       disp_valid_q, disp_valid_d;
  logic [SBID_W-1:0]          disp_sbid_q, disp_sbid_d;
  logic                       cmpl_valid_q, cmpl_valid_d;
  logic [SBID_W-1:0]          cmpl_sbid_q, cmpl_sbid_d;
  logic [63:0]                cmpl_data_q, cmpl_data_d;

  logic              free_any;
  logic [SBID_W-1:0] free_idx;
  logic              cmpl_hit;
  logic              cmpl_ok;
  logic              fence_block;
  logic              halt;
  logic              acc;

  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    cmpl_hit = 1'b0;
    for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
      if (!alloc_q[i] && !free_any) begin
        free_any = 1'b1;
        free_idx = SBID_W'(i);
      end
      // Out-of-range ids never match any index, so they fall into the error path.
      if (bus.VPU_COMPLETED_SBID == SBID_W'(i) && alloc_q[i]) cmpl_hit = 1'b1;
    end
    cmpl_ok     = bus.VPU_COMPLETED_VALID && cmpl_hit;
    fence_block = bus.CORE_FENCE && (outstanding_q != '0);
    halt        = (credits_q == '0) || !free_any || fence_block;
    acc         = bus.CORE_ISSUE_VALID && !halt && !RST;

    // Free and allocate both look at pre-edge state, so they never target the same entry.
    alloc_d = alloc_q;
    for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
      if (cmpl_ok && bus.VPU_COMPLETED_SBID == SBID_W'(i)) alloc_d[i] = 1'b0;
      if (acc && free_idx == SBID_W'(i)) alloc_d[i] = 1'b1;
    end
    outstanding_d = outstanding_q + OW'(acc) - OW'(cmpl_ok);

    err_d     = err_q;
    credits_d = credits_q;
    if (bus.VPU_COMPLETED_VALID && !cmpl_hit) err_d = 1'b1;
    if (acc && !bus.VPU_ISSUE_CREDIT) begin
      credits_d = credits_q - CW'(1);
    end else if (!acc && bus.VPU_ISSUE_CREDIT) begin
      if (credits_q == CW'(MAX_CREDITS)) err_d = 1'b1;
      else                               credits_d = credits_q + CW'(1);
    end

    disp_valid_d = acc;
    disp_sbid_d  = acc ? free_idx : '0;
    cmpl_valid_d = cmpl_ok;
    cmpl_sbid_d  = cmpl_ok ? bus.VPU_COMPLETED_SBID : '0;
    cmpl_data_d  = cmpl_ok ? bus.VPU_COMPLETED_DEST : '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      credits_q     <= CW'(MAX_CREDITS);
      alloc_q       <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      disp_valid_q  <= 1'b0;
      disp_sbid_q   <= '0;
      cmpl_valid_q  <= 1'b0;
      cmpl_sbid_q   <= '0;
      cmpl_data_q   <= '0;
    end else begin
      credits_q     <= credits_d;
      alloc_q       <= alloc_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      disp_valid_q  <= disp_valid_d;
      disp_sbid_q   <= disp_sbid_d;
      cmpl_valid_q  <= cmpl_valid_d;
      cmpl_sbid_q   <= cmpl_sbid_d;
      cmpl_data_q   <= cmpl_data_d;
    end
  end

  assign bus.CORE_HALT             = halt;
  assign bus.CORE_COMPLETED_VALID  = cmpl_valid_q;
  assign bus.CORE_COMPLETED_DATA   = cmpl_data_q;
  assign bus.CORE_COMPLETED_SBID   = cmpl_sbid_q;

  assign bus.VPU_ISSUE_VALID       = acc;
  assign bus.VPU_ISSUE_INSTR       = bus.CORE_ISSUE_INSTR;
  assign bus.VPU_ISSUE_SBID        = free_idx;
  assign bus.VPU_ISSUE_VSEW        = bus.CORE_ISSUE_SEW;
  assign bus.VPU_ISSUE_VL          = bus.CORE_ISSUE_VL;
  assign bus.VPU_ISSUE_VSTART      = '0;
  assign bus.VPU_ISSUE_VXRM        = '0;
  assign bus.VPU_ISSUE_FRM         = '0;
  assign bus.VPU_ISSUE_VLMUL       = '0;
  assign bus.VPU_ISSUE_VILL        = 1'b0;
  assign bus.VPU_ISSUE_SCALAR_OPND = '0;

  assign bus.VPU_DISPATCH_NEXT_SENIOR = disp_valid_q;
  assign bus.VPU_DISPATCH_KILL        = 1'b0;
  assign bus.VPU_DISPATCH_SBID        = disp_sbid_q;

  assign OUTSTANDING = outstanding_q;
  assign ERR         = err_q;

endmodule

// File: doc/ovi_issue_tracker.md
OVI_ISSUE_TRACKER -- requirements
Module: ovi_issue_tracker

Interface
REQ-001 Parameter MAX_CREDITS, default 4, is the initial VPU issue-credit count (range 1..15).
REQ-002 Parameter MAX_OUTSTANDING, default 4, is the number of scoreboard entries (power of 2, range 2..32).
REQ-003 Parameter SBID_W, default 5, is the sb_id width (2**SBID_W >= MAX_OUTSTANDING).
REQ-004 CLK  in  1  sole clock, all state updates on rising edge.
REQ-005 RST  in  1  asynchronous, active-high reset.
REQ-006 CORE_ISSUE_VALID / CORE_ISSUE_INSTR / CORE_ISSUE_SEW / CORE_ISSUE_VL  in  1/32/3/15  core issue request with its vsew and vl.
REQ-007 CORE_FENCE  in  1  level; while high, no new issue is accepted until the outstanding count is 0.
REQ-008 CORE_HALT  out  1  stall to core.
REQ-009 CORE_COMPLETED_VALID / CORE_COMPLETED_DATA / CORE_COMPLETED_SBID  out  1/64/SBID_W  completion forwarded to core.
REQ-010 VPU_ISSUE_VALID / VPU_ISSUE_INSTR / VPU_ISSUE_SBID / VPU_ISSUE_VSEW / VPU_ISSUE_VL  out  1/32/SBID_W/3/15  OVI issue bus; vstart, vxrm, frm, vlmul, vill and scalar_opnd are driven 0.
REQ-011 VPU_ISSUE_CREDIT  in  1  one-cycle credit return pulse.
REQ-012 VPU_DISPATCH_NEXT_SENIOR / VPU_DISPATCH_KILL / VPU_DISPATCH_SBID  out  1/1/SBID_W  OVI dispatch bus.
REQ-013 VPU_COMPLETED_VALID / VPU_COMPLETED_SBID / VPU_COMPLETED_DEST  in  1/SBID_W/64  OVI completion bus.
REQ-014 OUTSTANDING  out  $clog2(MAX_OUTSTANDING+1)  count of allocated scoreboard entries.
REQ-015 ERR  out  1  sticky protocol-error flag.

Function
REQ-016 Issue acceptance (acc) SHALL be CORE_ISSUE_VALID && credits>0 && a free entry exists && !fence_block && !RST.
REQ-017 fence_block SHALL be CORE_FENCE && OUTSTANDING!=0.
REQ-018 CORE_HALT SHALL be combinational: credits==0 || no free entry || fence_block.
REQ-019 VPU_ISSUE_VALID SHALL equal acc in the same cycle; instr, vsew and vl are passed through combinationally.
REQ-020 VPU_ISSUE_SBID SHALL be the lowest-index free scoreboard entry; that entry is marked allocated at the edge where acc=1.
REQ-021 Credit counter, width $clog2(MAX_CREDITS+1): -1 on acc; +1 on VPU_ISSUE_CREDIT; unchanged when both occur in the same cycle.
REQ-022 A credit return that would exceed MAX_CREDITS SHALL saturate the counter at MAX_CREDITS and set ERR.
REQ-023 Dispatch SHALL be registered: VPU_DISPATCH_NEXT_SENIOR=1 exactly one cycle after each acc, with VPU_DISPATCH_SBID equal to the issued sb_id; VPU_DISPATCH_KILL is always 0.
REQ-024 Back-to-back accepts SHALL produce back-to-back dispatch pulses in issue order.
REQ-025 On VPU_COMPLETED_VALID with the sb_id allocated, the entry SHALL be freed at that edge; CORE_COMPLETED_* SHALL be registered copies one cycle later (DATA=DEST, SBID=sb_id).
REQ-026 On VPU_COMPLETED_VALID with the sb_id unallocated or >= MAX_OUTSTANDING, ERR SHALL set, no entry changes and no core completion is produced.
REQ-027 A completion and an accept in the same cycle SHALL both take effect; a freed entry is not reusable until the next cycle (the free search uses the pre-edge state).
REQ-028 OUTSTANDING SHALL equal the popcount of allocated entries, updated at the same edge as alloc/free (+1, -1 or net 0).
REQ-029 ERR SHALL stay set until reset.

Reset
REQ-030 While RST is high: credits=MAX_CREDITS, all entries free, OUTSTANDING=0, ERR=0, dispatch and completion outputs 0, VPU_ISSUE_VALID=0.
REQ-031 Reset asserted mid-operation SHALL discard in-flight entries; completions arriving after reset SHALL set ERR.

Verification
REQ-032 After reset, drive 4 consecutive issues with defaults -> sb_ids 0,1,2,3, NEXT_SENIOR pulses in cycles 2-5, credits=0, CORE_HALT=1 on the 5th cycle.
REQ-033 With credits=0, pulse VPU_ISSUE_CREDIT once -> exactly one further issue is accepted, and CORE_HALT returns high.
REQ-034 Complete sb_id 2 out of order while ids 0-3 are allocated -> CORE_COMPLETED_SBID=2 one cycle later, OUTSTANDING 4->3, and the next issue takes sb_id 2.
REQ-035 In the same cycle, issue with credits=1 and a credit pulse -> credits stay 1 and the issue is accepted.
REQ-036 Assert CORE_FENCE with 2 outstanding -> no issue is accepted until both complete, then an issue is accepted the cycle after OUTSTANDING=0.
REQ-037 Complete an unallocated sb_id 7 and give a 5th credit return at credits=4 -> ERR=1 and stays set, with credits=4.
